// File: rtl/sift_kp_collector_pkg.sv
// ============================================================================
// Module  : sift_kp_collector_pkg
// Brief   : Shared FSM encodings, field widths and kp_data layout for the
//           SIFT keypoint collector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sift_kp_collector_pkg;

    localparam int c_ADDR_W   = 18;
    localparam int c_MAG_W    = 8;
    localparam int c_DIR_W    = 6;
    localparam int c_KP_W     = 1 + c_ADDR_W + c_MAG_W + c_DIR_W;

    localparam int c_OCT_B    = 32;
    localparam int c_ADDR_MSB = 31;
    localparam int c_ADDR_LSB = 14;
    localparam int c_MAG_MSB  = 13;
    localparam int c_MAG_LSB  = 6;
    localparam int c_DIR_MSB  = 5;

    localparam int c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_OCT1  = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_OCT2  = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_DRAIN = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 3'd4;

    typedef struct packed {
        logic                oct;
        logic [c_ADDR_W-1:0] addr;
        logic [c_MAG_W-1:0]  mag;
        logic [c_DIR_W-1:0]  dir;
    } kp_entry_t;

endpackage

`default_nettype wire

// File: rtl/sift_kp_collector_fifo.sv
// ============================================================================
// Module  : sift_kp_collector_fifo
// Brief   : Synchronous show-ahead FIFO, depth 2**AW; a push into a full FIFO
//           is accepted when a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sift_kp_collector_fifo #(
    parameter int AW = 6,
    parameter int W  = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_wr_ok
);

    localparam int c_DEPTH = 1 << AW;

    logic [W-1:0] r_mem [c_DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_wr_ok = w_push;

endmodule

`default_nettype wire

// File: rtl/sift_kp_collector.sv
// ============================================================================
// Module  : sift_kp_collector
// Brief   : Captures keypoints from the sift_feat stream into a FIFO with
//           octave tagging, per-octave counters and frame-done status.
//           Optional macro KP_MAG_THR_EN gates capture on mag >= mag_thr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sift_kp_collector
    import sift_kp_collector_pkg::*;
#(
    parameter int FIFO_AW = 6,
    parameter int CNT_W   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_en,
    input  logic                kp,
    input  logic [c_ADDR_W-1:0] kp_addr,
    input  logic [c_MAG_W-1:0]  mag,
    input  logic [c_DIR_W-1:0]  dir,
    input  logic                complete1,
    input  logic                complete2,
    input  logic [c_MAG_W-1:0]  mag_thr,
    output logic                kp_valid,
    input  logic                kp_ready,
    output logic [c_KP_W-1:0]   kp_data,
    output logic [CNT_W-1:0]    kp_cnt1,
    output logic [CNT_W-1:0]    kp_cnt2,
    output logic                overflow,
    output logic                frame_done
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic              r_c1_d;
    logic              r_c2_d;
    logic              w_c1_rise;
    logic              w_c2_rise;
    logic              w_cap_phase;
    logic              w_oct;
    logic              w_clear;
    logic              w_thr_ok;
    logic              w_cap;
    logic              w_empty;
    logic              w_wr_ok;
    kp_entry_t         w_entry;
    logic [CNT_W-1:0]  r_cnt1;
    logic [CNT_W-1:0]  r_cnt2;
    logic              r_overflow;

    assign w_c1_rise = complete1 & ~r_c1_d;
    assign w_c2_rise = complete2 & ~r_c2_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_c1_d  <= 1'b0;
            r_c2_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c1_d  <= complete1;
            r_c2_d  <= complete2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (in_en)     w_state_nxt = complete1 ? c_ST_OCT2 : c_ST_OCT1;
            c_ST_OCT1:  if (w_c1_rise) w_state_nxt = c_ST_OCT2;
            c_ST_OCT2:  if (w_c2_rise) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_empty)   w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (!complete2) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_cap_phase = (r_state == c_ST_OCT1) || (r_state == c_ST_OCT2);
        w_oct       = (r_state == c_ST_OCT2);
        w_clear     = (r_state == c_ST_DONE) && !complete2;
        frame_done  = (r_state == c_ST_DONE);
    end

`ifdef KP_MAG_THR_EN
    assign w_thr_ok = (mag >= mag_thr);
`else
    logic w_unused_thr;
    assign w_unused_thr = ^mag_thr;
    assign w_thr_ok     = 1'b1;
`endif

    // Octave comes from the current state, so an edge in the capture cycle
    // still tags the entry with the pre-edge octave.
    assign w_cap   = in_en & kp & w_cap_phase & w_thr_ok;
    assign w_entry = '{oct: w_oct, addr: kp_addr, mag: mag, dir: dir};

    sift_kp_collector_fifo #(
        .AW (FIFO_AW),
        .W  (c_KP_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cap),
        .i_wdata (w_entry),
        .i_pop   (kp_ready),
        .o_rdata (kp_data),
        .o_empty (w_empty),
        .o_wr_ok (w_wr_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok && !w_oct && (r_cnt1 != {CNT_W{1'b1}}))
                r_cnt1 <= r_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_wr_ok && w_oct && (r_cnt2 != {CNT_W{1'b1}}))
                r_cnt2 <= r_cnt2 + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_cap && !w_wr_ok)
                r_overflow <= 1'b1;
        end
    end

    assign kp_valid = ~w_empty;
    assign kp_cnt1  = r_cnt1;
    assign kp_cnt2  = r_cnt2;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sift_kp_collector.sv
// ============================================================================
// Module  : tb_sift_kp_collector
// Brief   : Randomized self-checking bench for sift_kp_collector against a
//           queue-based frame model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sift_kp_collector;
    import sift_kp_collector_pkg::*;

    localparam int c_DEPTH   = 64;
    localparam int c_CNT_MAX = 4095;
`ifdef KP_MAG_THR_EN
    localparam bit c_MAG_EN = 1'b1;
`else
    localparam bit c_MAG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_en = 1'b0, kp = 1'b0, kp_ready = 1'b0;
    logic        complete1 = 1'b0, complete2 = 1'b0;
    logic [17:0] kp_addr = '0;
    logic [7:0]  mag = '0, mag_thr = '0;
    logic [5:0]  dir = '0;
    logic        kp_valid, overflow, frame_done;
    logic [32:0] kp_data;
    logic [11:0] kp_cnt1, kp_cnt2;

    int total = 0;
    int bad   = 0;

    sift_kp_collector #(.FIFO_AW(6), .CNT_W(12)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .kp(kp), .kp_addr(kp_addr),
        .mag(mag), .dir(dir), .complete1(complete1), .complete2(complete2),
        .mag_thr(mag_thr), .kp_valid(kp_valid), .kp_ready(kp_ready),
        .kp_data(kp_data), .kp_cnt1(kp_cnt1), .kp_cnt2(kp_cnt2),
        .overflow(overflow), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Frame model: phase 0 idle, 1 octave 1, 2 octave 2, 3 drain, 4 done.
    logic [32:0] mq[$];
    int          ph;
    int          m_cnt1, m_cnt2;
    bit          m_ovf, pc1, pc2;
    logic [59:0] lg_exp[$], lg_obs[$];
    logic [32:0] pop_obs[$];

    task automatic model_reset();
        mq.delete(); lg_exp.delete(); lg_obs.delete(); pop_obs.delete();
        ph = 0; m_cnt1 = 0; m_cnt2 = 0; m_ovf = 0; pc1 = 0; pc2 = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        in_en = 0; kp = 0; kp_ready = 0; complete1 = 0; complete2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Drives one cycle, logs observed vs. modelled outputs, advances the model.
    task automatic cycle(input logic en, input logic k, input logic [17:0] a,
                         input logic [7:0] m, input logic [5:0] d,
                         input logic rdy, input logic c1, input logic c2);
        int   sz;
        bit   pop, cap;
        in_en = en; kp = k; kp_addr = a; mag = m; dir = d;
        kp_ready = rdy; complete1 = c1; complete2 = c2;
        sz = mq.size();
        lg_exp.push_back({sz > 0, (sz > 0) ? mq[0] : 33'd0,
                          12'(m_cnt1), 12'(m_cnt2), m_ovf, ph == 4});
        lg_obs.push_back({kp_valid, kp_valid ? kp_data : 33'd0,
                          kp_cnt1, kp_cnt2, overflow, frame_done});
        if (rdy && kp_valid) pop_obs.push_back(kp_data);
        pop = rdy && (sz > 0);
        cap = en && k && (ph == 1 || ph == 2) && (!c_MAG_EN || m >= mag_thr);
        if (pop) void'(mq.pop_front());
        if (cap) begin
            if (sz < c_DEPTH || pop) begin
                mq.push_back({ph == 2, a, m, d});
                if (ph == 1) begin if (m_cnt1 < c_CNT_MAX) m_cnt1++; end
                else         begin if (m_cnt2 < c_CNT_MAX) m_cnt2++; end
            end else m_ovf = 1;
        end
        case (ph)
            0: if (en) ph = c1 ? 2 : 1;
            1: if (c1 && !pc1) ph = 2;
            2: if (c2 && !pc2) ph = 3;
            3: if (sz == 0) ph = 4;
            4: if (!c2) begin ph = 0; m_cnt1 = 0; m_cnt2 = 0; m_ovf = 0; end
            default: ph = 0;
        endcase
        pc1 = c1; pc2 = c2;
        @(posedge clk); #1;
    endtask

    task automatic kpc(input logic [17:0] a, input logic rdy, input logic c1, input logic c2);
        cycle(1, 1, a, 8'($urandom), {2'b00, 4'($urandom)}, rdy, c1, c2);
    endtask

    task automatic idle(input int n, input logic rdy, input logic c1, input logic c2);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, '0, rdy, c1, c2);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total++; if (kp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", kp_valid); end
        total++; if (kp_data !== 33'd0) begin bad++; $display("FAIL reset_data got=%h want=0", kp_data); end
        total++; if ({kp_cnt1, kp_cnt2} !== 24'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", {kp_cnt1, kp_cnt2}); end
        total++; if ({overflow, frame_done} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b want=00", {overflow, frame_done}); end
        apply_reset();
    endtask

    task automatic test_octave1();
        logic [17:0] want [3] = '{18'd10, 18'd20, 18'd30};
        apply_reset();
        cycle(1, 0, '0, '0, '0, 1, 0, 0);
        kpc(18'd10, 1, 0, 0); idle(1, 1, 0, 0);
        kpc(18'd20, 1, 0, 0); kpc(18'd30, 1, 0, 0);
        idle(4, 1, 0, 0);
        total++; if (kp_cnt1 !== 12'd3) begin bad++; $display("FAIL oct1_cnt1 got=%0d want=3", kp_cnt1); end
        total++; if (pop_obs.size() != 3) begin bad++; $display("FAIL oct1_pops got=%0d want=3", pop_obs.size()); end
        for (int i = 0; i < pop_obs.size() && i < 3; i++) begin
            total++;
            if ({pop_obs[i][c_OCT_B], pop_obs[i][c_ADDR_MSB:c_ADDR_LSB]} !== {1'b0, want[i]}) begin
                bad++; $display("FAIL oct1_entry[%0d] got=%h want_addr=%0d oct=0", i, pop_obs[i], want[i]);
            end
        end
        for (int i = 0; i < lg_exp.size(); i++) begin
            total++; if (lg_obs[i] !== lg_exp[i]) begin bad++; $display("FAIL oct1_trace[%0d] got=%h want=%h", i, lg_obs[i], lg_exp[i]); end
        end
    endtask

    task automatic test_octave2_done();
        int n = 0;
        apply_reset();
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        kpc(18'd5, 0, 0, 0);
        kpc(18'd6, 0, 1, 0);
        kpc(18'd7, 0, 1, 0); kpc(18'd8, 0, 1, 0);
        idle(1, 0, 1, 1);
        while (!frame_done && n < 40) begin idle(1, 1, 1, 1); n++; end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL oct2_frame_done got=%b want=1", frame_done); end
        total++; if (kp_cnt2 !== 12'd2) begin bad++; $display("FAIL oct2_cnt2 got=%0d want=2", kp_cnt2); end
        total++; if (kp_cnt1 !== 12'd2) begin bad++; $display("FAIL oct2_cnt1 got=%0d want=2", kp_cnt1); end
        total++; if (pop_obs.size() != 4) begin bad++; $display("FAIL oct2_pops got=%0d want=4", pop_obs.size()); end
        for (int i = 0; i < pop_obs.size() && i < 4; i++) begin
            total++;
            if (pop_obs[i][c_OCT_B] !== (i >= 2)) begin bad++; $display("FAIL oct2_octbit[%0d] got=%b want=%b", i, pop_obs[i][c_OCT_B], i >= 2); end
        end
        kpc(18'd9, 1, 1, 1);
        idle(2, 1, 1, 0);
        total++; if ({frame_done, kp_cnt1, kp_cnt2} !== 25'd0) begin bad++; $display("FAIL oct2_clear got=%h want=0", {frame_done, kp_cnt1, kp_cnt2}); end
        for (int i = 0; i < lg_exp.size(); i++) begin
            total++; if (lg_obs[i] !== lg_exp[i]) begin bad++; $display("FAIL oct2_trace[%0d] got=%h want=%h", i, lg_obs[i], lg_exp[i]); end
        end
    endtask

    task automatic test_full_pushpop();
        apply_reset();
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 64; i++) kpc(18'(i + 100), 0, 0, 0);
        total++; if ({kp_cnt1, overflow} !== {12'd64, 1'b0}) begin bad++; $display("FAIL full_fill got=%0d/%b want=64/0", kp_cnt1, overflow); end
        kpc(18'd999, 1, 0, 0);
        total++; if ({kp_cnt1, overflow, kp_valid} !== {12'd65, 1'b0, 1'b1}) begin bad++; $display("FAIL full_pushpop got=%0d/%b/%b want=65/0/1", kp_cnt1, overflow, kp_valid); end
        idle(70, 1, 0, 0);
        total++; if (pop_obs.size() != 65) begin bad++; $display("FAIL full_pops got=%0d want=65", pop_obs.size()); end
        for (int i = 0; i < lg_exp.size(); i++) begin
            total++; if (lg_obs[i] !== lg_exp[i]) begin bad++; $display("FAIL full_trace[%0d] got=%h want=%h", i, lg_obs[i], lg_exp[i]); end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 65; i++) kpc(18'(i * 7), 0, 0, 0);
        total++; if ({kp_cnt1, overflow} !== {12'd64, 1'b1}) begin bad++; $display("FAIL ovf_fill got=%0d/%b want=64/1", kp_cnt1, overflow); end
        for (int i = 0; i < 200 && pop_obs.size() < 64; i++) idle(1, 1'($urandom_range(0, 1)), 0, 0);
        idle(3, 1, 0, 0);
        total++; if (pop_obs.size() != 64) begin bad++; $display("FAIL ovf_pops got=%0d want=64", pop_obs.size()); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        for (int i = 0; i < lg_exp.size(); i++) begin
            total++; if (lg_obs[i] !== lg_exp[i]) begin bad++; $display("FAIL ovf_trace[%0d] got=%h want=%h", i, lg_obs[i], lg_exp[i]); end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        cycle(1, 0, '0, '0, '0, 1, 0, 0);
        for (int i = 0; i < 4100; i++) kpc(18'(i), 1, 0, 0);
        idle(2, 1, 0, 0);
        total++; if (kp_cnt1 !== 12'd4095) begin bad++; $display("FAIL sat_cnt1 got=%0d want=4095", kp_cnt1); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sat_ovf got=%b want=0", overflow); end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        idle(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) kpc(18'(i), 0, 1, 0);
        total++; if ({kp_valid, kp_cnt2} !== {1'b1, 12'd10}) begin bad++; $display("FAIL mid_pre got=%b/%0d want=1/10", kp_valid, kp_cnt2); end
        rst = 1'b0;
        #1;
        total++; if ({kp_valid, kp_cnt1, kp_cnt2, overflow, frame_done} !== 27'd0) begin
            bad++; $display("FAIL mid_reset got=%b/%0d/%0d/%b/%b want=0", kp_valid, kp_cnt1, kp_cnt2, overflow, frame_done);
        end
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
        complete1 = 0;
        kpc(18'd77, 0, 0, 0);
        total++; if ({kp_valid, kp_cnt1} !== 13'd0) begin bad++; $display("FAIL mid_idle got=%b/%0d want=0/0", kp_valid, kp_cnt1); end
        kpc(18'd78, 0, 0, 0);
        total++; if ({kp_valid, kp_cnt1} !== {1'b1, 12'd1}) begin bad++; $display("FAIL mid_restart got=%b/%0d want=1/1", kp_valid, kp_cnt1); end
    endtask

    task automatic test_mag_thr();
        logic [7:0] mg [3] = '{8'd49, 8'd50, 8'd200};
        int exp_n;
        apply_reset();
        mag_thr = 8'd50;
        cycle(1, 0, '0, '0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 18'(i + 1), mg[i], 6'd3, 1, 0, 0);
        idle(3, 1, 0, 0);
        exp_n = c_MAG_EN ? 2 : 3;
        total++; if (kp_cnt1 !== 12'(exp_n)) begin bad++; $display("FAIL thr_cnt1 got=%0d want=%0d", kp_cnt1, exp_n); end
        total++; if (pop_obs.size() != exp_n) begin bad++; $display("FAIL thr_pops got=%0d want=%0d", pop_obs.size(), exp_n); end
        if (pop_obs.size() > 0) begin
            total++;
            if (pop_obs[0][c_MAG_MSB:c_MAG_LSB] !== mg[3 - exp_n]) begin
                bad++; $display("FAIL thr_first_mag got=%0d want=%0d", pop_obs[0][c_MAG_MSB:c_MAG_LSB], mg[3 - exp_n]);
            end
        end
        mag_thr = 8'd0;
    endtask

    task automatic test_random();
        int n = 0;
        apply_reset();
        mag_thr = 8'($urandom);
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom), ($urandom_range(0, 2) == 0), 18'($urandom), 8'($urandom),
                  {2'b00, 4'($urandom)}, ($urandom_range(0, 3) == 0), 0, 0);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom), ($urandom_range(0, 1) == 0), 18'($urandom), 8'($urandom),
                  {2'b00, 4'($urandom)}, 1'($urandom), 1, 0);
        while (!frame_done && n < 2000) begin
            cycle(1'($urandom), 1'($urandom), 18'($urandom), 8'($urandom), 6'd0, 1'($urandom), 1, 1);
            n++;
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rand_frame_done got=%b want=1", frame_done); end
        idle(3, 1, 1, 0);
        for (int i = 0; i < lg_exp.size(); i++) begin
            total++; if (lg_obs[i] !== lg_exp[i]) begin bad++; $display("FAIL rand_trace[%0d] got=%h want=%h", i, lg_obs[i], lg_exp[i]); end
        end
        mag_thr = 8'd0;
    endtask

    initial begin
        test_reset();
        test_octave1();
        test_octave2_done();
        test_full_pushpop();
        test_overflow();
        test_saturate();
        test_reset_midframe();
        test_mag_thr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
